// File: rtl/uart_pkg.sv
// Shared types and constants for the 9-bit UART transmitter.
// Optional even parity is enabled with the UART_TX_PARITY_EN macro.
package uart_pkg;

  localparam int DATA_BITS            = 9;
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Send/ready handshake plus the serial line of the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 send;
  logic [DATA_BITS-1:0] data;
  logic                 tx;
  logic                 ready;

  modport master (output send, output data, input tx, input ready);
  modport slave  (input send, input data, output tx, output ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_done_o
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    bit_done_o = 1'b0;
    cnt_d      = cnt_q;
    if (clear_i) begin
      cnt_d = 16'd0;
    end else if (enable_i) begin
      if (cnt_q == LAST_CNT) begin
        bit_done_o = 1'b1;
        cnt_d      = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 9-bit UART transmitter, 9N1 by default; 9E1 when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
  input logic      clock,
  input logic      reset_n,
  uart_tx_if.slave bus
);
  import uart_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

  uart_state_t          state_q;
  uart_state_t          state_d;
  logic [3:0]           bit_idx_q;
  logic [3:0]           bit_idx_d;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] data_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 ready_q;
  logic                 ready_d;
  logic                 accept_s;
  logic                 bit_done_s;
  logic                 cnt_clr_s;
  logic                 cnt_en_s;

  // Counter idles at zero so every state is entered with a fresh bit time.
  assign cnt_clr_s = (state_q == IDLE);
  assign cnt_en_s  = (state_q != IDLE);
  assign accept_s  = ready_q && bus.send;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_i    (cnt_clr_s),
    .enable_i   (cnt_en_s),
    .bit_done_o (bit_done_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_idx_q <= 4'd0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = START;
        else          state_d = IDLE;
      end
      START: begin
        if (bit_done_s) state_d = DATA;
        else            state_d = START;
      end
      DATA: begin
        if (bit_done_s && (bit_idx_q == LAST_IDX)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done_s) state_d = STOP;
        else            state_d = PARITY;
      end
`endif
      STOP: begin
        if (bit_done_s) state_d = IDLE;
        else            state_d = STOP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so tx/ready change on the same edge as the state.
  always_comb begin
    if (accept_s) data_d = bus.data;
    else          data_d = data_q;

    if ((state_q == DATA) && (state_d == DATA)) begin
      if (bit_done_s) bit_idx_d = bit_idx_q + 4'd1;
      else            bit_idx_d = bit_idx_q;
    end else begin
      bit_idx_d = 4'd0;
    end

    tx_d    = 1'b1;
    ready_d = 1'b0;
    case (state_d)
      IDLE:   begin tx_d = 1'b1;                ready_d = 1'b1; end
      START:  begin tx_d = 1'b0;                ready_d = 1'b0; end
      DATA:   begin tx_d = data_q[bit_idx_d];   ready_d = 1'b0; end
`ifdef UART_TX_PARITY_EN
      PARITY: begin tx_d = even_parity(data_q); ready_d = 1'b0; end
`endif
      STOP:   begin tx_d = 1'b1;                ready_d = 1'b0; end
      default: begin tx_d = 1'b1;               ready_d = 1'b1; end
    endcase
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx (fast DUT) plus a directed check on a default-rate DUT.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int C      = 8;
  localparam int C_LONG = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 12;
`else
  localparam int NBITS = 11;
`endif
  localparam int FRAME = NBITS * C;

  typedef struct {
    logic [8:0] word;
    int         cyc;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  uart_tx_if bus();
  uart_tx_if bus_l();

  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(DATA_BITS)) u_dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));
  uart_tx #(.CLKS_PER_BIT(C_LONG), .DATA_BITS(DATA_BITS)) u_dut_long (
    .clock(clock), .reset_n(reset_n), .bus(bus_l));

  int   checks   = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   busy     = 0;
  int   accepted = 0;
  int   frames   = 0;
  int   aborted  = 0;
  exp_t sb[$];

  logic        in_frame = 1'b0;
  logic        sb_valid = 1'b0;
  logic        seen_bit = 1'b1;
  logic        bad      = 1'b0;
  int          pos      = 0;
  logic [11:0] bits     = '0;
  exp_t        cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected line levels, LSB first: start, data[0..8], [even parity], stop.
  function automatic logic [11:0] frame_bits(input logic [8:0] w);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^w, w, 1'b0};
`else
    return {1'b1, 1'b1, w, 1'b0};
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  // Reference model: a frame occupies the line for FRAME cycles after acceptance.
  initial forever begin
    @(posedge clock);
    cyc++;
    if (!reset_n) begin
      busy = 0;
    end else if (busy == 0) begin
      if (bus.send) begin
        sb.push_back('{bus.data, cyc});
        busy = FRAME;
        accepted++;
      end
    end else begin
      busy--;
    end
  end

  initial forever begin
    @(negedge clock);
    check("ready", bus.ready, (!reset_n || busy == 0));
  end

  // Monitor: decode frames off tx and compare each bit time against the scoreboard.
  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      if (in_frame) aborted++;
      in_frame = 1'b0;
    end else begin
      if (!in_frame && bus.tx == 1'b0) begin
        in_frame = 1'b1;
        pos      = 0;
        bad      = 1'b0;
        if (sb.size() == 0) begin
          sb_valid = 1'b0;
          checks++;
          fails++;
          $display("FAIL spurious_frame: start bit seen at cycle %0d, expected no frame", cyc);
        end else begin
          cur      = sb.pop_front();
          sb_valid = 1'b1;
          bits     = frame_bits(cur.word);
          check("start_latency", cyc, cur.cyc);
        end
      end
      if (in_frame) begin
        if (!bad) seen_bit = bus.tx;
        if (bus.tx !== bits[pos / C]) bad = 1'b1;
        if ((pos % C) == C - 1) begin
          if (sb_valid)
            check($sformatf("frame_bit%0d_word%03h", pos / C, cur.word), seen_bit, bits[pos / C]);
          bad = 1'b0;
        end
        pos++;
        if (pos == FRAME) begin
          in_frame = 1'b0;
          frames++;
        end
      end
    end
  end

  initial begin
    int          low;
    int          f0;
    logic [11:0] lbits;
    bus.send   = 1'b0;
    bus.data   = '0;
    bus_l.send = 1'b0;
    bus_l.data = '0;
    tick(3);
    check("rst_tx", bus.tx, 1'b1);
    check("rst_ready", bus.ready, 1'b1);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_tx", bus.tx, 1'b1);
      check("idle_ready", bus.ready, 1'b1);
    end

    // Default-rate DUT: bit centres and ready-low duration.
    bus_l.data = 9'b101010101;
    bus_l.send = 1'b1;
    tick(1);
    bus_l.send = 1'b0;
    lbits = frame_bits(9'b101010101);
    low   = 0;
    for (int i = 0; i <= NBITS * C_LONG; i++) begin
      if (!bus_l.ready) low++;
      if (i < NBITS * C_LONG && (i % C_LONG) == C_LONG / 2)
        check($sformatf("long_bit%0d", i / C_LONG), bus_l.tx, lbits[i / C_LONG]);
      if (i == NBITS * C_LONG) check("long_ready_back", bus_l.ready, 1'b1);
      tick(1);
    end
    check("long_ready_low_cycles", low, NBITS * C_LONG);

    // Back-to-back frames with send held high.
    bus.data = 9'h1FF;
    bus.send = 1'b1;
    tick(1);
    bus.data = 9'h000;
    tick(FRAME);
    check("b2b_idle_tx", bus.tx, 1'b1);
    tick(1);
    check("b2b_second_start", bus.tx, 1'b0);
    bus.send = 1'b0;
    tick(FRAME + 5);

    // Mid-frame send and data change must be ignored.
    f0 = frames;
    bus.data = 9'h0A5;
    bus.send = 1'b1;
    tick(1);
    bus.send = 1'b0;
    tick(30);
    bus.data = 9'h15A;
    bus.send = 1'b1;
    tick(2);
    bus.send = 1'b0;
    tick(FRAME + 20);
    check("midframe_frames", frames - f0, 1);

    // Reset during data bit 4, then send on the first edge after release.
    bus.data = 9'h1EF;
    bus.send = 1'b1;
    tick(1);
    bus.send = 1'b0;
    tick(5 * C + 3);
    reset_n = 1'b0;
    #1;
    check("midrst_tx", bus.tx, 1'b1);
    check("midrst_ready", bus.ready, 1'b1);
    tick(2);
    f0 = frames;
    bus.data = 9'h133;
    bus.send = 1'b1;
    reset_n  = 1'b1;
    tick(1);
    bus.send = 1'b0;
    tick(FRAME + 5);
    check("post_reset_frame", frames - f0, 1);
    check("aborted_frames", aborted, 1);

    bus.data = 9'h007;
    bus.send = 1'b1;
    tick(1);
    bus.send = 1'b0;
    tick(FRAME + 5);

    for (int i = 0; i < 1500; i++) begin
      bus.send = ($urandom_range(0, 7) == 0);
      bus.data = 9'($urandom);
      tick(1);
    end
    bus.send = 1'b0;
    tick(FRAME + 10);

    check("scoreboard_empty", sb.size(), 0);
    check("frame_count", frames + aborted, accepted);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (legal range 2..65535).
REQ-002 Parameter DATA_BITS, default 9, data bits per frame; fixed at 9 for this block.
REQ-003 Port clock  input  1  single system clock, all logic on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port send  input  1  request to transmit; sampled on rising clock edge.
REQ-006 Port data  input  9  word to transmit; captured on the accepting edge.
REQ-007 Port tx  output  1  serial line; idle level high.
REQ-008 Port ready  output  1  high when a new send is accepted.

Function
REQ-009 Frame format SHALL be 9N1: one start bit (0), data[0] first through data[8], one stop bit (1).
REQ-010 Each frame bit SHALL be driven on tx for exactly CLKS_PER_BIT cycles; total frame 11*CLKS_PER_BIT cycles (12* with parity).
REQ-011 A send SHALL be accepted on a rising edge where send=1 and ready=1; data SHALL be registered in that cycle.
REQ-012 tx SHALL go low (start bit) on the edge after acceptance; ready SHALL drop on that same edge.
REQ-013 send and data changes while ready=0 SHALL be ignored; the captured word SHALL not change mid-frame.
REQ-014 State machine SHALL use states IDLE, START, DATA, PARITY (only when enabled), STOP.
REQ-015 Transitions: IDLE->START on accept; START->DATA after one bit time; DATA->STOP (or PARITY) after data[8] bit time; PARITY->STOP after one bit time; STOP->IDLE after one bit time.
REQ-016 A 4-bit bit index SHALL count 0..8 in DATA and clear in every other state.
REQ-017 The bit-time counter SHALL restart at 0 on every state entry; no drift accumulates across the frame.
REQ-018 ready SHALL be 1 only in IDLE; it SHALL rise on the edge that ends the stop bit.
REQ-019 send held high continuously SHALL start the next frame on the edge after ready rises, giving exactly one idle cycle between the stop bit and the next start bit.
REQ-020 tx SHALL be registered (no combinational glitches).

Reset
REQ-021 While reset_n=0: tx=1, ready=1, state=IDLE, counters=0, captured data=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) with tx=1 and ready=1.
REQ-023 First accept after reset release SHALL be possible on the first rising edge with reset_n=1.

Configuration
REQ-024 Macro UART_TX_PARITY_EN: when defined, an even-parity bit (XOR of data[8:0]) SHALL be sent in PARITY between data[8] and stop (9E1).
REQ-025 Without UART_TX_PARITY_EN, PARITY state and logic SHALL be absent and the frame is 9N1.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum type (uart_state_t) and the DATA_BITS and default CLKS_PER_BIT constants.
REQ-027 Sub-module uart_baud_gen SHALL implement the bit-time counter, with inputs clear/enable and output bit_done pulsing on the last cycle of each bit.

Verification
REQ-028 Reset, then hold idle 20 cycles -> tx=1, ready=1 throughout.
REQ-029 CLKS_PER_BIT=434, data=9'b101010101, send pulsed 1 cycle after reset release -> tx sequence 0,1,0,1,0,1,0,1,0,1,1, each 434 cycles; ready low 4774 cycles, high by cycle 4776 after accept.
REQ-030 CLKS_PER_BIT=8, send held high, data=9'h1FF then 9'h000 -> two back-to-back frames separated by exactly one idle cycle; second frame carries 0x000.
REQ-031 CLKS_PER_BIT=8, data changed and send pulsed mid-frame -> frame unchanged, no second frame started.
REQ-032 CLKS_PER_BIT=8, reset_n dropped during data bit 4 -> tx=1 and ready=1 immediately; next send yields a complete, correct frame.
REQ-033 UART_TX_PARITY_EN defined, data=9'h007 -> parity bit 1 after data[8], frame length 12 bit times.
